rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port ioctl_download  in  1  high while a ROM download is in progress.
REQ-005 SHALL have port ioctl_wr  in  1  one-cycle strobe; ioctl_addr and ioctl_data are valid.
REQ-006 SHALL have port ioctl_addr  in  25  byte address of the word (bit 0 always 0).
REQ-007 SHALL have port ioctl_data  in  16  file word, little-endian byte order.
REQ-008 SHALL have port ioctl_wait  out  1  back-pressure to the downloader.
REQ-009 SHALL have port wraddr  out  25  memory write address.
REQ-010 SHALL have port din  out  16  memory write data, byte-swapped.
REQ-011 SHALL have port we_req  out  1  toggle request to the memory write port.
REQ-012 SHALL have port we_ack  in  1  toggle acknowledge; a request is complete when we_ack == we_req.
REQ-013 SHALL have port rom_size  out  25  bytes loaded (highest accepted address + 2).
REQ-014 SHALL have port rom_mask  out  25  smallest 2^n-1 >= rom_size-1, valid after load_done.
REQ-015 SHALL have port load_done  out  1  one-cycle pulse when the last word is acknowledged.
REQ-016 SHALL have port overflow  out  1  sticky; a write arrived while the FIFO was full.

Function
REQ-017 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-018 A rising edge of ioctl_download (registered previous value 0, current 1) SHALL, in any state, enter LOAD and clear the FIFO, rom_size and overflow.
REQ-019 In LOAD, a falling edge of ioctl_download SHALL enter DRAIN.
REQ-020 In DRAIN, FIFO empty with we_req == we_ack SHALL enter DONE, compute rom_mask and assert load_done.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 In LOAD, ioctl_wr with FIFO not full SHALL push {ioctl_addr, ioctl_data} in the same cycle.
REQ-023 In LOAD, ioctl_wr with FIFO full SHALL drop the word and set overflow.
REQ-024 ioctl_wr in IDLE, DRAIN or DONE SHALL be ignored.
REQ-025 ioctl_wait SHALL be registered and SHALL be high in any cycle where FIFO count >= DEPTH-1 at the previous edge, leaving one slot of slack.
REQ-026 Issue rule: when FIFO not empty and we_req == we_ack, the head SHALL be popped. On the same edge, wraddr <= head.addr, din <= {head.data[7:0], head.data[15:8]}, and we_req SHALL toggle.
REQ-027 At most one request SHALL be outstanding at any time.
REQ-028 wraddr and din SHALL be held stable until the acknowledge arrives.
REQ-029 A simultaneous push and pop SHALL leave the count unchanged and lose no data.
REQ-030 rom_size SHALL update on each accepted push to max(rom_size, ioctl_addr+2).
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.
REQ-032 rom_mask arithmetic: rom_size 0 SHALL give mask 0.
REQ-033 rom_mask arithmetic: rom_size equal to a power of two 2^n SHALL give 2^n-1.
REQ-034 A restart (REQ-018) while a request is outstanding SHALL NOT touch we_req. New requests SHALL wait for the acknowledge per REQ-026.

Reset
REQ-035 On reset, the state SHALL be IDLE and the FIFO empty.
REQ-036 On reset, ioctl_wait, load_done and overflow SHALL be 0, and rom_size, rom_mask, wraddr and din SHALL be 0.
REQ-037 On reset, we_req SHALL load the current we_ack, so no spurious request is issued.
REQ-038 Reset asserted mid-download SHALL discard all queued words. The next rising edge of ioctl_download SHALL start a fresh load.

Verification
REQ-039 Bench SHALL cover: download words 0x1234@0, 0xABCD@2, then ack each after 3 cycles -> wraddr 0/2, din 0x3412/0xCDAB, load_done one cycle after the second ack, rom_size 4, rom_mask 3.
REQ-040 Bench SHALL cover: DEPTH=4, we_ack held, ioctl_wr every cycle -> ioctl_wait high after the 3rd queued word, no word lost if the source stops within one cycle, overflow stays 0.
REQ-041 Bench SHALL cover: ignoring ioctl_wait with FIFO full -> extra word dropped, overflow=1 until the next download start.
REQ-042 Bench SHALL cover: words out of order (addr 0x100 then 0x000), 0x180000 bytes total -> rom_size 0x180000, rom_mask 0x1FFFFF.
REQ-043 Bench SHALL cover: reset during LOAD with one request outstanding -> we_req == we_ack after reset, no further toggles, outputs at reset values.
REQ-044 Bench SHALL cover: new ioctl_download rising edge during DRAIN -> FIFO cleared, state LOAD, no load_done pulse for the aborted load.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: buffers downloader words in a small FIFO and replays them, one at
// a time, to a toggle-handshake memory write port. It also tracks the loaded
// image size and the address mask that covers it.
module rom_loader #(
   parameter int DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [15:0] ioctl_data,
   output logic        ioctl_wait,
   output logic [24:0] wraddr,
   output logic [15:0] din,
   output logic        we_req,
   input  logic        we_ack,
   output logic [24:0] rom_size,
   output logic [24:0] rom_mask,
   output logic        load_done,
   output logic        overflow
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] LP_ZERO    = (AW+1)'(0);
   localparam logic [AW:0] LP_ONE     = (AW+1)'(1);
   localparam logic [AW:0] LP_FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_WAIT    = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] LP_PTR_0 = (AW)'(0);
   localparam logic [AW-1:0] LP_PTR_1 = (AW)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Smallest all-ones value covering every byte address below size; an empty
   // image has no addresses, so it maps to zero rather than all ones.
   function automatic logic [24:0] f_mask(input logic [24:0] size);
      logic [24:0] v;
      if (size == 25'd0) begin
         v = 25'd0;
      end else begin
         v = size - 25'd1;
         v = v | (v >> 1);
         v = v | (v >> 2);
         v = v | (v >> 4);
         v = v | (v >> 8);
         v = v | (v >> 16);
      end
      return v;
   endfunction

   state_t        r_state;
   state_t        w_state_next;
   logic          r_dl_prev;
   logic [24:0]   r_fifo_addr [DEPTH];
   logic [15:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [AW:0]   w_count_next;
   logic          w_dl_rise;
   logic          w_empty;
   logic          w_full;
   logic          w_port_free;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic [24:0]   w_size_cand;
   logic          r_wait;
   logic [24:0]   r_wraddr;
   logic [15:0]   r_din;
   logic          r_we_req;
   logic [24:0]   r_rom_size;
   logic [24:0]   r_rom_mask;
   logic          r_load_done;
   logic          r_overflow;

   assign ioctl_wait = r_wait;
   assign wraddr     = r_wraddr;
   assign din        = r_din;
   assign we_req     = r_we_req;
   assign rom_size   = r_rom_size;
   assign rom_mask   = r_rom_mask;
   assign load_done  = r_load_done;
   assign overflow   = r_overflow;

   // FIFO push/pop decisions; a download restart overrides everything else.
   always_comb begin
      w_dl_rise   = ioctl_download & ~r_dl_prev;
      w_empty     = (r_count == LP_ZERO);
      w_full      = (r_count == LP_FULL);
      w_port_free = (r_we_req == we_ack);
      w_push      = ~w_dl_rise & (r_state == S_LOAD) & ioctl_wr & ~w_full;
      w_drop      = ~w_dl_rise & (r_state == S_LOAD) & ioctl_wr & w_full;
      w_pop       = ~w_dl_rise & ~w_empty & w_port_free;
      w_size_cand = ioctl_addr + 25'd2;
      if (w_dl_rise) begin
         w_count_next = LP_ZERO;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + LP_ONE;
            2'b01:   w_count_next = r_count - LP_ONE;
            default: w_count_next = r_count;
         endcase
      end
   end

   // Next-state logic for the load sequence.
   always_comb begin
      w_state_next = r_state;
      if (w_dl_rise) begin
         w_state_next = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE: w_state_next = S_IDLE;
            S_LOAD: begin
               if (!ioctl_download) begin
                  w_state_next = S_DRAIN;
               end else begin
                  w_state_next = S_LOAD;
               end
            end
            S_DRAIN: begin
               if (w_empty && w_port_free) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_DRAIN;
               end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FIFO storage; stale entries are harmless because the pointers gate reads.
   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= ioctl_addr;
         r_fifo_data[r_wr_ptr] <= ioctl_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_wr_ptr <= LP_PTR_0;
         r_rd_ptr <= LP_PTR_0;
         r_count  <= LP_ZERO;
      end else if (w_dl_rise) begin
         r_wr_ptr <= LP_PTR_0;
         r_rd_ptr <= LP_PTR_0;
         r_count  <= LP_ZERO;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_1;
         end
         r_count <= w_count_next;
      end
   end

   // Memory write issue: load address/data and toggle the request together.
   // Reset copies the acknowledge so no request appears to be pending.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_wraddr <= 25'd0;
         r_din    <= 16'd0;
         r_we_req <= we_ack;
      end else if (w_pop) begin
         r_wraddr <= r_fifo_addr[r_rd_ptr];
         r_din    <= {r_fifo_data[r_rd_ptr][7:0], r_fifo_data[r_rd_ptr][15:8]};
         r_we_req <= ~r_we_req;
      end
   end

   // Status: edge detect, back-pressure, size/mask tracking, done and overflow.
   // The edge detector samples the live input on reset so a download line
   // already high does not look like a fresh start once reset drops.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_dl_prev   <= ioctl_download;
         r_wait      <= 1'b0;
         r_rom_size  <= 25'd0;
         r_rom_mask  <= 25'd0;
         r_load_done <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_dl_prev   <= ioctl_download;
         r_wait      <= (w_count_next >= LP_WAIT);
         r_load_done <= (w_state_next == S_DONE);
         if (w_dl_rise) begin
            r_rom_size <= 25'd0;
            r_overflow <= 1'b0;
         end else begin
            if (w_push && (w_size_cand > r_rom_size)) begin
               r_rom_size <= w_size_cand;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
         end
         if (w_state_next == S_DONE) begin
            r_rom_mask <= f_mask(r_rom_size);
         end
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench; words expected at the memory port are queued
// when driven and compared when the loader toggles its write request.
module tb_rom_loader;

   logic        clk_sys;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [15:0] ioctl_data;
   logic        ioctl_wait;
   logic [24:0] wraddr;
   logic [15:0] din;
   logic        we_req;
   logic        we_ack;
   logic [24:0] rom_size;
   logic [24:0] rom_mask;
   logic        load_done;
   logic        overflow;

   rom_loader #(.DEPTH(4)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wait     (ioctl_wait),
      .wraddr         (wraddr),
      .din            (din),
      .we_req         (we_req),
      .we_ack         (we_ack),
      .rom_size       (rom_size),
      .rom_mask       (rom_mask),
      .load_done      (load_done),
      .overflow       (overflow)
   );

   typedef struct packed {
      logic [24:0] addr;
      logic [15:0] din;
   } exp_t;

   exp_t        sb[$];
   int          n_tests;
   int          n_fail;
   int          cyc;
   int          ack_cyc;
   int          toggles;
   int          done_pulses;
   bit          ack_en;
   int          ack_delay;
   bit          pending;
   int          ack_cnt;
   logic        prev_req;
   logic [24:0] cur_addr;
   logic [15:0] cur_din;
   exp_t        e;

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk_sys);
         cyc++;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] swap16(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Memory-side responder: checks each issued write against the scoreboard and
   // acknowledges it ack_delay cycles later while ack_en is set.
   initial begin
      pending = 1'b0;
      forever begin
         @(posedge clk_sys);
         #2;
         if (reset) begin
            pending  = 1'b0;
            prev_req = we_req;
         end else begin
            if (load_done) done_pulses++;
            if (we_req !== prev_req) begin
               prev_req = we_req;
               toggles++;
               check_val("single_outstanding", 32'(pending), 32'd0);
               check_val("issue_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check_val("wraddr", 32'(wraddr), 32'(e.addr));
                  check_val("din", 32'(din), 32'(e.din));
                  cur_addr = e.addr;
                  cur_din  = e.din;
                  pending  = 1'b1;
                  ack_cnt  = ack_delay;
               end
            end else if (pending && ack_en) begin
               if (ack_cnt > 1) begin
                  ack_cnt--;
               end else begin
                  check_val("wraddr_stable", 32'(wraddr), 32'(cur_addr));
                  check_val("din_stable", 32'(din), 32'(cur_din));
                  we_ack  = we_req;
                  ack_cyc = cyc;
                  pending = 1'b0;
               end
            end
         end
      end
   end

   task automatic drive_word(input logic [24:0] a, input logic [15:0] d, input bit accept);
      exp_t x;
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      if (accept) begin
         x.addr = a;
         x.din  = swap16(d);
         sb.push_back(x);
      end
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic start_load();
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic wait_done(output int at);
      bit seen;
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (load_done) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      check_val("load_done_seen", 32'(seen), 32'd1);
   endtask

   task automatic finish_load(input string tag, input logic [24:0] exp_size,
                              input logic [24:0] exp_mask, output int at);
      ioctl_download = 1'b0;
      tick();
      ack_en = 1'b1;
      wait_done(at);
      check_val({tag, "_size"}, 32'(rom_size), 32'(exp_size));
      check_val({tag, "_mask"}, 32'(rom_mask), 32'(exp_mask));
      tick();
      check_val({tag, "_done_pulse"}, 32'(load_done), 32'd0);
      check_val({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int at;
      int p0;
      int t0;
      n_tests = 0; n_fail = 0; toggles = 0; done_pulses = 0; ack_cyc = 0;
      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = 25'd0; ioctl_data = 16'd0; we_ack = 1'b1;
      ack_en = 1'b1; ack_delay = 3;
      repeat (3) tick();
      reset = 1'b0;
      check_val("rst_we_req", 32'(we_req), 32'd1);
      check_val("rst_wait", 32'(ioctl_wait), 32'd0);
      check_val("rst_done", 32'(load_done), 32'd0);
      check_val("rst_ovf", 32'(overflow), 32'd0);
      check_val("rst_size", 32'(rom_size), 32'd0);
      check_val("rst_mask", 32'(rom_mask), 32'd0);
      check_val("rst_wraddr", 32'(wraddr), 32'd0);
      check_val("rst_din", 32'(din), 32'd0);
      repeat (3) tick();
      check_val("rst_no_toggle", 32'(toggles), 32'd0);

      // Two words, acknowledged after 3 cycles each.
      start_load();
      drive_word(25'h0, 16'h1234, 1'b1);
      drive_word(25'h2, 16'hABCD, 1'b1);
      finish_load("basic", 25'd4, 25'd3, at);
      check_val("basic_done_timing", 32'(at), 32'(ack_cyc + 1));

      // Held acknowledge: back-pressure after the third queued word.
      ack_en = 1'b0; ack_delay = 1;
      start_load();
      for (int i = 0; i < 5; i++) begin
         drive_word(25'h10 + 25'(2 * i), 16'h1000 + 16'(i), 1'b1);
         check_val($sformatf("wait_w%0d", i), 32'(ioctl_wait), 32'(i >= 3));
      end
      check_val("bp_no_ovf", 32'(overflow), 32'd0);
      finish_load("bp", 25'h1A, 25'h1F, at);
      check_val("bp_ovf_end", 32'(overflow), 32'd0);

      // Ignore back-pressure: the word after the FIFO fills is dropped.
      ack_en = 1'b0;
      start_load();
      for (int i = 0; i < 6; i++) begin
         drive_word((i < 5) ? 25'(2 * i) : 25'h100, 16'h2000 + 16'(i), (i < 5));
         check_val($sformatf("ovf_w%0d", i), 32'(overflow), 32'(i == 5));
      end
      finish_load("ovf", 25'hA, 25'hF, at);
      check_val("ovf_sticky", 32'(overflow), 32'd1);

      // Out-of-order words; size follows the highest address.
      start_load();
      check_val("restart_ovf_clr", 32'(overflow), 32'd0);
      check_val("restart_size_clr", 32'(rom_size), 32'd0);
      drive_word(25'h100, 16'h5AA5, 1'b1);
      check_val("ooo_size1", 32'(rom_size), 32'h102);
      drive_word(25'h000, 16'h0FF0, 1'b1);
      check_val("ooo_size2", 32'(rom_size), 32'h102);
      drive_word(25'h17FFFE, 16'hBEEF, 1'b1);
      check_val("ooo_size3", 32'(rom_size), 32'h180000);
      finish_load("big", 25'h180000, 25'h1FFFFF, at);

      // Empty download: size and mask both zero.
      start_load();
      finish_load("empty", 25'd0, 25'd0, at);

      // Restart during DRAIN with a request outstanding.
      ack_en = 1'b0;
      start_load();
      drive_word(25'h0, 16'h1111, 1'b1);
      drive_word(25'h2, 16'h2222, 1'b1);
      drive_word(25'h4, 16'h3333, 1'b1);
      ioctl_download = 1'b0;
      repeat (3) tick();
      p0 = done_pulses;
      while (sb.size() != 0) void'(sb.pop_back());
      start_load();
      check_val("abort_wait_clr", 32'(ioctl_wait), 32'd0);
      drive_word(25'h2, 16'h4444, 1'b1);
      repeat (3) tick();
      check_val("abort_no_done", 32'(done_pulses), 32'(p0));
      finish_load("abort", 25'd4, 25'd3, at);
      check_val("abort_one_done", 32'(done_pulses), 32'(p0 + 1));

      // Reset during LOAD with a request outstanding.
      ack_en = 1'b0;
      start_load();
      drive_word(25'h0, 16'h5555, 1'b1);
      drive_word(25'h2, 16'h6666, 1'b1);
      reset = 1'b1; ioctl_download = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      while (sb.size() != 0) void'(sb.pop_back());
      check_val("mid_rst_req_ack", 32'(we_req), 32'(we_ack));
      check_val("mid_rst_wait", 32'(ioctl_wait), 32'd0);
      check_val("mid_rst_ovf", 32'(overflow), 32'd0);
      check_val("mid_rst_size", 32'(rom_size), 32'd0);
      check_val("mid_rst_mask", 32'(rom_mask), 32'd0);
      check_val("mid_rst_wraddr", 32'(wraddr), 32'd0);
      check_val("mid_rst_din", 32'(din), 32'd0);
      check_val("mid_rst_done", 32'(load_done), 32'd0);
      t0 = toggles;
      ack_en = 1'b1;
      repeat (10) tick();
      check_val("mid_rst_no_toggle", 32'(toggles), 32'(t0));
      start_load();
      drive_word(25'h20, 16'h7777, 1'b1);
      finish_load("post_rst", 25'h22, 25'h3F, at);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
